mimo_det_scheduler: RTL

Front-end/back-end sequencer for the 4x4 16QAM K-best detector core. Accepts 4-lane input beats from upstream through a valid/ready handshake and buffers them. Launches each 10-beat frame into the detector as one unbroken 10-cycle burst, and tracks in-flight frames across the detector's fixed pipeline latency. Captures each 16-bit decision vector into a result FIFO with its own valid/ready handshake, and uses credit-based launch control so the non-stallable detector never overruns the result FIFO.

---
 rtl/mimo_det_scheduler.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mimo_det_scheduler.sv
// mimo_det_scheduler
//
// Sequencer around the 4x4 16QAM K-best detector core. Upstream beats
// are buffered in an input FIFO. Each frame is only launched once all of
// its beats are buffered, so the detector sees an unbroken burst. A tag
// shift register follows every launched frame through the fixed detector
// latency, and the matching decision vector is captured into a
// first-word-fall-through result FIFO. Credits count the free result
// slots that are not yet claimed by a frame in flight. This keeps the
// non-stallable detector from ever overrunning the result FIFO.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready        upstream beat handshake
//   in0..in3                 upstream beat lanes
//   det_in0..det_in3         registered lanes to the detector (0 when idle)
//   det_first                high while beat 0 of a frame is on det_in*
//   det_x                    detector decision vector
//   res_valid/res_ready      result FIFO handshake
//   res_x                    result FIFO head (0 when empty)
//   busy                     frame being fed or any frame in flight
module mimo_det_scheduler #(
    parameter int IN_WL       = 16,
    parameter int FRAME_BEATS = 10,
    parameter int LATENCY     = 132,
    parameter int IN_DEPTH    = 32,
    parameter int RES_DEPTH   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_WL-1:0] in0,
    input  logic [IN_WL-1:0] in1,
    input  logic [IN_WL-1:0] in2,
    input  logic [IN_WL-1:0] in3,
    output logic [IN_WL-1:0] det_in0,
    output logic [IN_WL-1:0] det_in1,
    output logic [IN_WL-1:0] det_in2,
    output logic [IN_WL-1:0] det_in3,
    output logic             det_first,
    input  logic [15:0]      det_x,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_x,
    output logic             busy
);

    localparam int IPW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int ICW = $clog2(IN_DEPTH + 1);
    localparam int RPW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int RCW = $clog2(RES_DEPTH + 1);
    localparam int BCW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam int BW  = 4 * IN_WL;

    localparam logic [ICW-1:0] IN_FULL   = ICW'(IN_DEPTH);
    localparam logic [ICW-1:0] FRAME_N   = ICW'(FRAME_BEATS);
    localparam logic [IPW-1:0] IN_LAST   = IPW'(IN_DEPTH - 1);
    localparam logic [RCW-1:0] RES_FULL  = RCW'(RES_DEPTH);
    localparam logic [RPW-1:0] RES_LAST  = RPW'(RES_DEPTH - 1);
    localparam logic [BCW-1:0] BEAT_LAST = BCW'(FRAME_BEATS - 1);

    typedef enum logic {IDLE, FEED} state_t;

    state_t           state_q, state_d;
    logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [BW-1:0]    in_mem_q [IN_DEPTH];
    logic [IPW-1:0]   in_wr_q, in_wr_d, in_rd_q, in_rd_d;
    logic [ICW-1:0]   in_cnt_q, in_cnt_d;
    logic [15:0]      res_mem_q [RES_DEPTH];
    logic [RPW-1:0]   res_wr_q, res_wr_d, res_rd_q, res_rd_d;
    logic [RCW-1:0]   res_cnt_q, res_cnt_d;
    logic [RCW-1:0]   credits_q, credits_d;
    logic [LATENCY-1:0] tag_q, tag_d;
    logic [BW-1:0]    det_q, det_d;
    logic             det_first_q, det_first_d;

    logic in_push, pop, pop_first, res_push, res_pop;

    assign in_ready  = (in_cnt_q != IN_FULL);
    assign in_push   = in_valid && in_ready;
    assign res_valid = (res_cnt_q != '0);
    assign res_pop   = res_valid && res_ready;
    assign res_x     = res_valid ? res_mem_q[res_rd_q] : '0;
    // The result FIFO cannot fill while credits are honoured. The full
    // guard only protects its pointers if that ever breaks.
    assign res_push  = tag_q[LATENCY-1] && (res_cnt_q != RES_FULL);
    assign busy      = (state_q == FEED) || (tag_q != '0);

    assign det_in0   = det_q[IN_WL-1:0];
    assign det_in1   = det_q[2*IN_WL-1:IN_WL];
    assign det_in2   = det_q[3*IN_WL-1:2*IN_WL];
    assign det_in3   = det_q[4*IN_WL-1:3*IN_WL];
    assign det_first = det_first_q;

    // Launch control. A frame starts only when a full frame is already
    // buffered, and the test ignores a push in the same cycle. Beat 0 is
    // popped in the cycle the decision is made. Beats 1.. follow every
    // cycle. On the last beat the next frame may be chained with no
    // bubble. In that case the test discounts the beat being popped now.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        pop        = 1'b0;
        pop_first  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_cnt_q >= FRAME_N && credits_q != '0) begin
                    pop        = 1'b1;
                    pop_first  = 1'b1;
                    state_d    = FEED;
                    beat_cnt_d = BCW'(1);
                end
            end
            FEED: begin
                pop       = 1'b1;
                pop_first = (beat_cnt_q == '0);
                if (beat_cnt_q == BEAT_LAST) begin
                    beat_cnt_d = '0;
                    if (!(in_cnt_q > FRAME_N && credits_q != '0)) begin
                        state_d = IDLE;
                    end
                end else begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next-state for both FIFOs, the credit counter and the detector side.
    // A launch consumes a credit. A result accepted downstream returns one.
    always_comb begin
        in_wr_d = in_wr_q;
        if (in_push) in_wr_d = (in_wr_q == IN_LAST) ? '0 : in_wr_q + 1'b1;
        in_rd_d = in_rd_q;
        if (pop) in_rd_d = (in_rd_q == IN_LAST) ? '0 : in_rd_q + 1'b1;
        in_cnt_d = in_cnt_q;
        if (in_push && !pop) in_cnt_d = in_cnt_q + 1'b1;
        else if (!in_push && pop) in_cnt_d = in_cnt_q - 1'b1;

        res_wr_d = res_wr_q;
        if (res_push) res_wr_d = (res_wr_q == RES_LAST) ? '0 : res_wr_q + 1'b1;
        res_rd_d = res_rd_q;
        if (res_pop) res_rd_d = (res_rd_q == RES_LAST) ? '0 : res_rd_q + 1'b1;
        res_cnt_d = res_cnt_q;
        if (res_push && !res_pop) res_cnt_d = res_cnt_q + 1'b1;
        else if (!res_push && res_pop) res_cnt_d = res_cnt_q - 1'b1;

        credits_d = credits_q;
        if (pop_first && !res_pop) credits_d = credits_q - 1'b1;
        else if (!pop_first && res_pop) credits_d = credits_q + 1'b1;

        det_d       = pop ? in_mem_q[in_rd_q] : '0;
        det_first_d = pop_first;
        tag_d       = {tag_q[LATENCY-2:0], det_first_q};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            in_wr_q     <= '0;
            in_rd_q     <= '0;
            in_cnt_q    <= '0;
            res_wr_q    <= '0;
            res_rd_q    <= '0;
            res_cnt_q   <= '0;
            credits_q   <= RES_FULL;
            tag_q       <= '0;
            det_q       <= '0;
            det_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            in_wr_q     <= in_wr_d;
            in_rd_q     <= in_rd_d;
            in_cnt_q    <= in_cnt_d;
            res_wr_q    <= res_wr_d;
            res_rd_q    <= res_rd_d;
            res_cnt_q   <= res_cnt_d;
            credits_q   <= credits_d;
            tag_q       <= tag_d;
            det_q       <= det_d;
            det_first_q <= det_first_d;
        end
    end

    // Storage arrays need no reset. Occupancy is tracked by the counters.
    always_ff @(posedge clk) begin
        if (in_push) in_mem_q[in_wr_q] <= {in3, in2, in1, in0};
        if (res_push) res_mem_q[res_wr_q] <= det_x;
    end

endmodule
